qpp_deinterleaver: RTL and testbench
====================================

Name: qpp_deinterleaver

Overview:
- Streaming LTE turbo QPP de-interleaver; inverse of the coder interleaver.
- The coder interleaver maps natural input bit i to interleaved position pi(i) = (f1*i + f2*i*i) mod K.
- This block accepts the interleaved stream serially, buffers one block of K bits, then emits the natural-order stream.
- Sits on the decoder side between the channel/demapper bit stream and the constituent decoder input. Supports K = 6144 or K = 1056.

Parameters:
- F1_6144, 263, QPP f1 for K=6144
- F2_6144, 480, QPP f2 for K=6144
- F1_1056, 17, QPP f1 for K=1056
- F2_1056, 66, QPP f2 for K=1056
- AW, 13, address/index width (must hold 6143)

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- k_eq_6144  input  1  block size select: 1 = 6144, 0 = 1056; sampled at block start
- in_valid  input  1  in_bit valid
- in_ready  output  1  block can accept a bit
- in_bit  input  1  interleaved bit, arriving in interleaved-index order j = 0..K-1
- out_valid  output  1  out_bit valid
- out_ready  input  1  downstream accepts out_bit
- out_bit  output  1  de-interleaved bit for natural index i
- out_last  output  1  high with out_valid on i = K-1
- busy  output  1  high in LOAD (after first bit) and DRAIN

Behaviour:
- Reset: asynchronous, active-high. Clock and reset named clock and reset.
- Reset values: in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0; state IDLE; all counters 0. Buffer contents are don't-care.
- Reset asserted mid-block abandons the block with no partial output; next block starts fresh.
- Handshake: a transfer occurs when valid && ready on a rising edge.
  - in_ready depends only on state.
  - out_valid, once high, holds with stable out_bit/out_last until out_ready.
- States:
  - IDLE: in_ready=1. First accepted bit latches K from k_eq_6144, writes buf[0], sets j=1, goes to LOAD.
  - LOAD: in_ready=1. Each accepted bit writes buf[j], j++. Accepting bit j=K-1 moves to DRAIN on that edge. k_eq_6144 changes during LOAD/DRAIN are ignored.
  - DRAIN: in_ready=0. Address generator issues read of buf[pi(i)] whenever (!out_valid || out_ready) and reads remain.
    - Read data lands in the output register next cycle, giving one bit per cycle at full rate.
    - When the output with out_last is accepted, go to IDLE.
- Latency:
  - Synchronous-read buffer (1-cycle read latency).
  - First out_valid rises 2 cycles after the edge accepting input j=K-1.
  - Block throughput is K input cycles + K output cycles + 2.
- Address recursion (no multipliers):
  - pi(0)=0, g(0)=(f1+f2) mod K.
  - pi(i+1) = (pi(i)+g(i)) mod K.
  - g(i+1) = (g(i)+2*f2) mod K.
  - Each mod is a single conditional subtract of K on an AW+1-bit sum, since both operands are < K and 2*f2 < K.
- Output stall: when out_valid && !out_ready, the address generator, issue counter and output register all hold.
- Boundaries:
  - in_valid with in_ready=0 is ignored.
  - out_ready with out_valid=0 has no effect.
  - out_last asserts exactly once per block.
  - Back-to-back blocks: an IDLE in_valid on the cycle after the last output handshake is accepted.

Decomposition:
- Shared package holds:
  - K constants 6144 and 1056.
  - The four f1/f2 constants.
  - Precomputed (f1+f2) mod K and (2*f2) mod K for each K.
  - State encoding IDLE/LOAD/DRAIN.
  - AW.
- Sub-module qpp_addr_gen:
  - Inputs: clock, reset, start, advance, K select.
  - Outputs: pi, valid.
  - Implements the recursion; reusable by the encoder-side interleaver.
- Buffer is an inferred 6144x1 synchronous-read RAM inside the top module.

Test Plan:
- K=1056, input all zeros except interleaved j=83 → exactly out_bit=1 at natural i=1. Also j=298 → i=2, and j=645 → i=3. All other outputs 0. out_last on output 1056.
- K=6144, single 1 at j=743, then at j=2446 in a second back-to-back block → 1 at i=1 (block 1) and at i=2 (block 2). Each block emits exactly 6144 outputs.
- K=1056, random block A; feed pi-ordered B where B[pi(i)]=A[i] (golden model as in the coder interleaver check) → output equals A bit-for-bit. Repeat with out_ready randomly deasserted 50%: outputs stay identical, out_bit stable during stalls.
- k_eq_6144 toggled mid-LOAD of a 1056 block → block still completes after 1056 inputs. in_ready=0 throughout DRAIN; in_valid pulses during DRAIN are ignored.
- reset asserted at input j=500, then a fresh K=1056 block → all outputs at reset values immediately (asynchronous), no output from the aborted block, new block correct.
- Throughput check: out_ready held 1 → out_valid high for 1056 consecutive cycles, starting 2 cycles after the last input accept.

Source files
------------

// File: rtl/qpp_deinterleaver_pkg.sv
// QPP de-interleaver shared constants, state encoding and helpers.
// Used by the top, the address generator and any encoder-side reuse.
package qpp_deinterleaver_pkg;

  localparam int AW    = 13;
  localparam int DEPTH = 6144;

  localparam int F1_6144 = 263;
  localparam int F2_6144 = 480;
  localparam int F1_1056 = 17;
  localparam int F2_1056 = 66;

  localparam logic [AW-1:0] K_6144 = AW'(6144);
  localparam logic [AW-1:0] K_1056 = AW'(1056);

  localparam logic [AW-1:0] G0_6144 =
    AW'((F1_6144 + F2_6144) % 6144);
  localparam logic [AW-1:0] D_6144 =
    AW'((2 * F2_6144) % 6144);
  localparam logic [AW-1:0] G0_1056 =
    AW'((F1_1056 + F2_1056) % 1056);
  localparam logic [AW-1:0] D_1056 =
    AW'((2 * F2_1056) % 1056);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  // Both operands are below k, so one subtract folds the sum.
  function automatic logic [AW-1:0] mod_add(
    input logic [AW-1:0] a,
    input logic [AW-1:0] b,
    input logic [AW-1:0] k
  );
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] k_len(input logic sel);
    return sel ? K_6144 : K_1056;
  endfunction

endpackage

// File: rtl/qpp_deinterleaver_if.sv
// Bit-stream handshake bundle for the QPP de-interleaver.
// master drives input bits and output ready; slave is the block.
interface qpp_deinterleaver_if;

  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_last;

  modport master (
    output in_valid,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_last
  );

endinterface

// File: rtl/qpp_deinterleaver_addr_gen.sv
// QPP address generator: pi(i) by add-only recursion, no multipliers.
// start loads i=0; each advance steps to i+1 until K addresses issued.
module qpp_addr_gen
  import qpp_deinterleaver_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          advance,
  input  logic          k_eq_6144,
  output logic [AW-1:0] pi,
  output logic          valid,
  output logic          last
);

  logic          k_sel;
  logic [AW-1:0] g;
  logic [AW-1:0] cnt;
  logic [AW-1:0] k;
  logic [AW-1:0] d;

  assign k    = k_len(k_sel);
  assign d    = k_sel ? D_6144 : D_1056;
  assign last = valid && (cnt == k - AW'(1));

  // Step pi and its increment g together; drop valid after index K-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_sel <= 1'b0;
      pi    <= '0;
      g     <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (start) begin
      k_sel <= k_eq_6144;
      pi    <= '0;
      g     <= k_eq_6144 ? G0_6144 : G0_1056;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (advance && valid) begin
      pi  <= mod_add(pi, g, k);
      g   <= mod_add(g, d, k);
      cnt <= cnt + AW'(1);
      if (last) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qpp_deinterleaver.sv
// Streaming LTE turbo QPP de-interleaver (K = 6144 or 1056).
// Loads one block in interleaved order, then drains in natural order.
module qpp_deinterleaver
  import qpp_deinterleaver_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                k_eq_6144,
  qpp_deinterleaver_if.slave  bus,
  output logic                busy
);

  state_t        state;
  state_t        state_n;
  logic          k_sel;
  logic [AW-1:0] j;
  logic          drain_go;
  logic          in_fire;
  logic          out_fire;
  logic          wr_last;
  logic          issue;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          gen_valid;
  logic          gen_last;
  logic          mem [DEPTH];

  assign bus.in_ready = (state != DRAIN);
  assign busy         = (state != IDLE);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;
  assign wr_addr      = (state == IDLE) ? '0 : j;
  assign wr_last      = in_fire && (state == LOAD) &&
                        (j == k_len(k_sel) - AW'(1));
  assign issue        = (state == DRAIN) && gen_valid &&
                        (!bus.out_valid || bus.out_ready);

  qpp_addr_gen u_addr_gen (
    .clock     (clock),
    .reset     (reset),
    .start     (drain_go),
    .advance   (issue),
    .k_eq_6144 (k_sel),
    .pi        (rd_addr),
    .valid     (gen_valid),
    .last      (gen_last)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Load until K bits written, drain until the last bit is taken.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_fire) state_n = LOAD;
      LOAD:    if (wr_last) state_n = DRAIN;
      DRAIN:   if (out_fire && bus.out_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Write index, block size latch and the one-cycle drain kick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_sel    <= 1'b0;
      j        <= '0;
      drain_go <= 1'b0;
    end else begin
      drain_go <= wr_last;
      if (in_fire) begin
        if (state == IDLE) begin
          k_sel <= k_eq_6144;
          j     <= AW'(1);
        end else if (wr_last) begin
          j <= '0;
        end else begin
          j <= j + AW'(1);
        end
      end
    end
  end

  // Block buffer write port.
  always_ff @(posedge clock) begin
    if (in_fire) mem[wr_addr] <= bus.in_bit;
  end

  // Synchronous read lands straight in the output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_bit   <= 1'b0;
      bus.out_last  <= 1'b0;
    end else if (issue) begin
      bus.out_valid <= 1'b1;
      bus.out_bit   <= mem[rd_addr];
      bus.out_last  <= gen_last;
    end else if (out_fire) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qpp_deinterleaver.sv
// Bench for qpp_deinterleaver: directed and random blocks
// checked against a direct-formula QPP model.
module tb_qpp_deinterleaver;

  typedef struct {
    bit b;
    bit l;
  } exp_t;

  logic clock;
  logic reset;
  logic k_eq_6144;
  logic busy;

  qpp_deinterleaver_if bus ();

  qpp_deinterleaver dut (
    .clock     (clock),
    .reset     (reset),
    .k_eq_6144 (k_eq_6144),
    .bus       (bus),
    .busy      (busy)
  );

  int   checks;
  int   errors;
  int   cyc;
  int   last_hs_cyc;
  int   acc_cyc;
  int   first_acc_cyc;
  int   rdy_mode;
  exp_t exp_q[$];
  int   len_q[$];
  int   one_pos_q[$];
  bit   a_arr[6144];
  bit   b_arr[6144];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  function automatic int pi_f(input int i, input int k);
    longint f1;
    longint f2;
    f1 = (k == 6144) ? 263 : 17;
    f2 = (k == 6144) ? 480 : 66;
    return int'((f1 * i + f2 * i * i) % k);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_bit"}, int'(bus.out_bit), 0);
    chk({tag, "_out_last"}, int'(bus.out_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic clear_b();
    for (int i = 0; i < 6144; i++) b_arr[i] = 1'b0;
  endtask

  task automatic push_gather(input int k);
    for (int i = 0; i < k; i++)
      exp_q.push_back('{b: b_arr[pi_f(i, k)], l: (i == k - 1)});
  endtask

  task automatic make_random(input int k);
    for (int i = 0; i < k; i++) a_arr[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < k; i++) b_arr[pi_f(i, k)] = a_arr[i];
    for (int i = 0; i < k; i++)
      exp_q.push_back('{b: a_arr[i], l: (i == k - 1)});
  endtask

  task automatic put_bit(input bit b, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    while (!ok && t < 15000) begin
      @(negedge clock);
      ok = bus.in_ready;
      @(posedge clock);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
    if (!ok) chk("in_accept_timeout", 0, 1);
  endtask

  task automatic feed(input bit k6144, input int n,
                      input bit gaps, input bit tog);
    bit ok;
    k_eq_6144 = k6144;
    for (int j = 0; j < n; j++) begin
      if (gaps && j > 0 && $urandom_range(0, 7) == 0) begin
        @(posedge clock);
        #1;
      end
      if (tog && j > 0) k_eq_6144 = 1'($urandom_range(0, 1));
      put_bit(b_arr[j], ok);
      if (j == 0) first_acc_cyc = acc_cyc;
      if (!ok) return;
    end
    k_eq_6144 = k6144;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 15000) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("drain_done_left", exp_q.size(), 0);
  endtask

  task automatic blk_chk(input string name, input int k);
    int n;
    n = (len_q.size() > 0) ? len_q.pop_front() : -1;
    chk({name, "_block_len"}, n, k);
  endtask

  task automatic pos_chk(input string name, input int want);
    int p;
    p = (one_pos_q.size() > 0) ? one_pos_q.pop_front() : -1;
    chk(name, p, want);
  endtask

  // Compare process: every output handshake against the model queue.
  initial begin
    int   idx;
    bit   hv;
    bit   hb;
    bit   hl;
    exp_t e;
    idx = 0;
    hv  = 1'b0;
    hb  = 1'b0;
    hl  = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hv  = 1'b0;
        idx = 0;
      end else begin
        if (hv) begin
          checks++;
          if (!bus.out_valid || bus.out_bit !== hb ||
              bus.out_last !== hl) begin
            errors++;
            $display("FAIL stall_hold i=%0d got v=%0b b=%0b l=%0b want v=1 b=%0b l=%0b",
                     idx, bus.out_valid, bus.out_bit, bus.out_last, hb, hl);
          end
        end
        hv = bus.out_valid && !bus.out_ready;
        hb = bus.out_bit;
        hl = bus.out_last;
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out i=%0d got b=%0b l=%0b want none",
                     idx, bus.out_bit, bus.out_last);
          end else begin
            e = exp_q.pop_front();
            if (bus.out_bit !== e.b || bus.out_last !== e.l) begin
              errors++;
              $display("FAIL out_stream i=%0d got b=%0b l=%0b want b=%0b l=%0b",
                       idx, bus.out_bit, bus.out_last, e.b, e.l);
            end
          end
          if (bus.out_bit) one_pos_q.push_back(idx);
          idx++;
          if (bus.out_last) begin
            len_q.push_back(idx);
            idx = 0;
            last_hs_cyc = cyc + 1;
          end
        end
      end
    end
  end

  initial begin
    int run;
    checks       = 0;
    errors       = 0;
    rdy_mode     = 0;
    reset        = 1'b1;
    k_eq_6144    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("por");
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    chk("model_pi1_1056", pi_f(1, 1056), 83);
    chk("model_pi2_1056", pi_f(2, 1056), 298);
    chk("model_pi3_1056", pi_f(3, 1056), 645);
    chk("model_pi1_6144", pi_f(1, 6144), 743);
    chk("model_pi2_6144", pi_f(2, 6144), 2446);

    // Directed K=1056 with ones at j=83/298/645, plus latency/rate.
    clear_b();
    b_arr[83]  = 1'b1;
    b_arr[298] = 1'b1;
    b_arr[645] = 1'b1;
    one_pos_q.delete();
    push_gather(1056);
    feed(1'b0, 1056, 1'b0, 1'b0);
    @(negedge clock);
    chk("lat_cycle1_valid", int'(bus.out_valid), 0);
    chk("drain_in_ready", int'(bus.in_ready), 0);
    @(negedge clock);
    chk("lat_cycle2_valid", int'(bus.out_valid), 0);
    run = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clock);
      if (bus.out_valid) run++;
      else break;
    end
    chk("full_rate_run", run, 1056);
    @(posedge clock);
    #1;
    wait_done();
    @(negedge clock);
    chk("idle_busy", int'(busy), 0);
    chk("idle_in_ready", int'(bus.in_ready), 1);
    @(posedge clock);
    #1;
    blk_chk("k1056_dir", 1056);
    chk("k1056_ones", one_pos_q.size(), 3);
    pos_chk("k1056_one_a", 1);
    pos_chk("k1056_one_b", 2);
    pos_chk("k1056_one_c", 3);

    // Two back-to-back K=6144 blocks.
    clear_b();
    one_pos_q.delete();
    b_arr[743] = 1'b1;
    push_gather(6144);
    feed(1'b1, 6144, 1'b0, 1'b0);
    b_arr[743]  = 1'b0;
    b_arr[2446] = 1'b1;
    push_gather(6144);
    feed(1'b1, 6144, 1'b0, 1'b0);
    chk("b2b_accept_gap", first_acc_cyc - last_hs_cyc, 1);
    wait_done();
    blk_chk("k6144_blk1", 6144);
    blk_chk("k6144_blk2", 6144);
    chk("k6144_ones", one_pos_q.size(), 2);
    pos_chk("k6144_one_blk1", 1);
    pos_chk("k6144_one_blk2", 2);

    // Random K=1056, k select toggled during load, drain pulses.
    make_random(1056);
    feed(1'b0, 1056, 1'b1, 1'b1);
    @(negedge clock);
    chk("ktoggle_drain_ready", int'(bus.in_ready), 0);
    chk("ktoggle_busy", int'(busy), 1);
    @(posedge clock);
    #1;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_bit   = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("pulse_drain_ready", int'(bus.in_ready), 0);
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_done();
    blk_chk("rand_ktoggle", 1056);

    // Random K=1056 with 50% output back-pressure.
    rdy_mode = 1;
    make_random(1056);
    feed(1'b0, 1056, 1'b1, 1'b0);
    wait_done();
    rdy_mode = 0;
    blk_chk("rand_stall", 1056);

    // Reset after j=0..499 of a K=1056 block.
    make_random(1056);
    feed(1'b0, 500, 1'b0, 1'b0);
    @(negedge clock);
    chk("mid_load_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_load");
    exp_q.delete();
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset while an output is held under back-pressure.
    rdy_mode = 2;
    @(posedge clock);
    #1;
    clear_b();
    b_arr[0] = 1'b1;
    push_gather(1056);
    feed(1'b0, 1056, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk("held_out_valid", int'(bus.out_valid), 1);
    chk("held_out_bit", int'(bus.out_bit), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_drain");
    exp_q.delete();
    rdy_mode = 0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Fresh random block after the aborted ones.
    len_q.delete();
    make_random(1056);
    feed(1'b0, 1056, 1'b0, 1'b0);
    wait_done();
    blk_chk("after_reset", 1056);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
